// File: rtl/aes_128_stream_if.sv
// rtl/aes_128_stream_if.sv - block-in / result-out handshake bundle for aes_128_stream
interface aes_128_stream_if #(
  parameter int TAG_W      = 8,
  parameter int FIFO_DEPTH = 32
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [127:0]         in_state;
  logic [127:0]         in_key;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [127:0]         out_data;
  logic [TAG_W-1:0]     out_tag;
  logic [CW-1:0]        inflight;

  modport master (
    output in_valid, in_state, in_key, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, inflight
  );

  modport slave (
    input  in_valid, in_state, in_key, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, inflight
  );
endinterface

// File: rtl/aes_128_stream.sv
// rtl/aes_128_stream.sv - pipelined AES-128 encrypt core with tagged, credit-throttled FWFT output FIFO

// 21-register AES-128 encrypt pipeline: input AddRoundKey stage, then per round
// one key-expansion stage followed by one round stage. No control, no reset.
module aes_128_core (
  input  logic         clk,
  input  logic [127:0] i_state,
  input  logic [127:0] i_key,
  output logic [127:0] o_state
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table is stored entry 0 first (MSB), so entry x sits at bit offset 8*(255-x).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input int r);
    case (r)
      0: return 8'h01;
      1: return 8'h02;
      2: return 8'h04;
      3: return 8'h08;
      4: return 8'h10;
      5: return 8'h20;
      6: return 8'h40;
      7: return 8'h80;
      8: return 8'h1b;
      default: return 8'h36;
    endcase
  endfunction

  // Next round key from the current one (RotWord, SubWord, Rcon, xor chain).
  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c+r] = sbox(b[4*((c+r)%4)+r]);
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (!last) begin
        o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end else begin
        o[127-32*c -: 32] = {a0, a1, a2, a3};
      end
    end
    return o ^ k;
  endfunction

  logic [127:0] r_st  [0:20];
  logic [127:0] r_key [0:20];

  // Odd stages expand the key while the state waits; even stages apply the round.
  always_ff @(posedge clk) begin
    r_st[0]  <= i_state ^ i_key;
    r_key[0] <= i_key;
    for (int i = 1; i <= 20; i++) begin
      if (i[0]) begin
        r_st[i]  <= r_st[i-1];
        r_key[i] <= key_expand(r_key[i-1], rcon(i >> 1));
      end else begin
        r_st[i]  <= aes_round(r_st[i-1], r_key[i-1], i == 20);
        r_key[i] <= r_key[i-1];
      end
    end
  end

  assign o_state = r_st[20];
endmodule

// Streaming wrapper: valid/ready in, tag sideband, FWFT result FIFO, credit-based input gate.
module aes_128_stream #(
  parameter int LATENCY    = 21,
  parameter int FIFO_DEPTH = 32,
  parameter int TAG_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  aes_128_stream_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] PONE_C  = PW'(1);

  logic [127:0]           w_core_out;
  logic                   w_accept;
  logic                   w_pop;
  logic                   w_wr;
  logic                   w_empty;
  logic                   w_full;
  logic [LATENCY-1:0]     r_vpipe;
  logic [TAG_W-1:0]       r_tpipe [0:LATENCY-1];
  logic [127+TAG_W:0]     r_mem   [0:FIFO_DEPTH-1];
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [CW-1:0]          r_cnt;

  aes_128_core u_core (
    .clk     (clk),
    .i_state (bus.in_state),
    .i_key   (bus.in_key),
    .o_state (w_core_out)
  );

  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_pop        = bus.out_valid & bus.out_ready;
  assign w_wr         = r_vpipe[LATENCY-1];
  assign w_empty      = (r_wptr == r_rptr);
  assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign bus.in_ready = (r_cnt < DEPTH_C);
  assign bus.out_valid = !w_empty;
  assign bus.out_data = r_mem[r_rptr[AW-1:0]][127+TAG_W:TAG_W];
  assign bus.out_tag  = r_mem[r_rptr[AW-1:0]][TAG_W-1:0];
  assign bus.inflight = r_cnt;

  // Valid bits track only accepted blocks; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vpipe <= '0;
    else     r_vpipe <= {r_vpipe[LATENCY-2:0], w_accept};
  end

  // Tags ride alongside the core pipeline; content is meaningless where vpipe is 0.
  always_ff @(posedge clk) begin
    r_tpipe[0] <= bus.in_tag;
    for (int i = 1; i < LATENCY; i++) r_tpipe[i] <= r_tpipe[i-1];
  end

  // FIFO storage: captures the core output in the cycle its valid bit leaves the pipe.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= {w_core_out, r_tpipe[LATENCY-1]};
  end

  // Pointers (wrap bit distinguishes full from empty) and the credit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + PONE_C;
      if (w_pop) r_rptr <= r_rptr + PONE_C;
      if (w_accept && !w_pop)      r_cnt <= r_cnt + ONE_C;
      else if (!w_accept && w_pop) r_cnt <= r_cnt - ONE_C;
    end
  end

  // Credits bound pipe + FIFO contents, so a write can never meet a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_wr && w_full));
endmodule

// File: tb/tb_aes_128_stream.sv
// tb/tb_aes_128_stream.sv - directed-vector bench for aes_128_stream
module tb_aes_128_stream;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_128_stream_if #(.TAG_W(8), .FIFO_DEPTH(32)) bus ();

  aes_128_stream #(.LATENCY(21), .FIFO_DEPTH(32), .TAG_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [127:0] vk [7];
  logic [127:0] vp [7];
  logic [127:0] vc [7];
  logic [135:0] exp_q [$];
  int           lat_q [$];

  // free-running cycle index, read #1 after each edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vectors();
    vk[0] = 128'h000102030405060708090a0b0c0d0e0f; vp[0] = 128'h00112233445566778899aabbccddeeff;
    vc[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    vk[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c; vp[1] = 128'h3243f6a8885a308d313198a2e0370734;
    vc[1] = 128'h3925841d02dc09fbdc118597196a0b32;
    vk[2] = 128'h0;                                vp[2] = 128'h0;
    vc[2] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    vk[3] = 128'h2b7e151628aed2a6abf7158809cf4f3c; vp[3] = 128'h6bc1bee22e409f96e93d7e117393172a;
    vc[3] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    vk[4] = 128'h2b7e151628aed2a6abf7158809cf4f3c; vp[4] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    vc[4] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    vk[5] = 128'h2b7e151628aed2a6abf7158809cf4f3c; vp[5] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    vc[5] = 128'h43b1cd7f598ece23881b00e3ed030688;
    vk[6] = 128'h2b7e151628aed2a6abf7158809cf4f3c; vp[6] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    vc[6] = 128'h7b0c785e27e8ad3f8223207104725dd4;
  endtask

  task automatic drive_block(input int idx, input logic [7:0] tag, input logic v);
    bus.in_valid = v;
    bus.in_state = vp[idx % 7];
    bus.in_key   = vk[idx % 7];
    bus.in_tag   = tag;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    exp_q.delete();
    lat_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_state = '0; bus.in_key = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    step();
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.inflight !== 6'd0) begin failures++; $display("FAIL rst_inflight got=%0d exp=0", bus.inflight); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    rst = 1'b0;
    step();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_release in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_fips();
    int k;
    logic [127:0] held;
    do_reset();
    drive_block(0, 8'h5A, 1'b1);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL fips_ready got=%b exp=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.inflight !== 6'd1) begin failures++; $display("FAIL fips_inflight got=%0d exp=1", bus.inflight); end
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 40) begin step(); k++; end
    checks++; if (k !== 21) begin failures++; $display("FAIL fips_latency got=%0d exp=21", k); end
    checks++; if (bus.out_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      failures++; $display("FAIL fips_data got=%h exp=69c4e0d86a7b0430d8cdb78070b4c55a", bus.out_data);
    end
    checks++; if (bus.out_tag !== 8'h5A) begin failures++; $display("FAIL fips_tag got=%h exp=5a", bus.out_tag); end
    held = bus.out_data;
    step();
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
      failures++; $display("FAIL fips_hold valid=%b data=%h exp 1/%h", bus.out_valid, bus.out_data, held);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.inflight !== 6'd0) begin
      failures++; $display("FAIL fips_pop valid=%b inflight=%0d exp 0/0", bus.out_valid, bus.inflight);
    end
  endtask

  task automatic test_back_to_back();
    int sent, got, drops, a;
    logic [135:0] e;
    do_reset();
    sent = 0; got = 0; drops = 0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 400 && got < 100; t++) begin
      drive_block(sent, 8'(sent), sent < 100);
      if (sent < 100 && bus.in_ready !== 1'b1) drops++;
      if (bus.out_valid && bus.out_ready) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_extra got=%h/%h", bus.out_data, bus.out_tag); end
        else begin
          e = exp_q.pop_front();
          a = lat_q.pop_front();
          if ({bus.out_data, bus.out_tag} !== e) begin
            failures++; $display("FAIL b2b_data got=%h/%h exp=%h/%h", bus.out_data, bus.out_tag, e[135:8], e[7:0]);
          end
          checks++; if (cyc - a !== 21) begin failures++; $display("FAIL b2b_latency got=%0d exp=21", cyc - a); end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({vc[sent % 7], 8'(sent)});
        lat_q.push_back(cyc + 1);
        sent++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    checks++; if (got !== 100) begin failures++; $display("FAIL b2b_count got=%0d exp=100", got); end
    checks++; if (drops !== 0) begin failures++; $display("FAIL b2b_ready_drops got=%0d exp=0", drops); end
  endtask

  task automatic test_backpressure();
    int sent, got;
    logic [135:0] e;
    do_reset();
    sent = 0; got = 0;
    bus.out_ready = 1'b0;
    for (int t = 0; t < 60; t++) begin
      drive_block(sent, 8'(sent + 8'h40), 1'b1);
      if (bus.in_ready) begin exp_q.push_back({vc[sent % 7], 8'(sent + 8'h40)}); sent++; end
      step();
    end
    checks++; if (sent !== 32) begin failures++; $display("FAIL bp_accepted got=%0d exp=32", sent); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b exp=0", bus.in_ready); end
    checks++; if (bus.inflight !== 6'd32) begin failures++; $display("FAIL bp_inflight got=%0d exp=32", bus.inflight); end
    bus.out_ready = 1'b1;
    for (int t = 0; t < 200 && got < 40; t++) begin
      drive_block(sent, 8'(sent + 8'h40), sent < 40);
      if (bus.out_valid && bus.out_ready) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra got=%h/%h", bus.out_data, bus.out_tag); end
        else begin
          e = exp_q.pop_front();
          if ({bus.out_data, bus.out_tag} !== e) begin
            failures++; $display("FAIL bp_data got=%h/%h exp=%h/%h", bus.out_data, bus.out_tag, e[135:8], e[7:0]);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin exp_q.push_back({vc[sent % 7], 8'(sent + 8'h40)}); sent++; end
      step();
      if (t == 0) begin
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_return got=%b exp=1", bus.in_ready); end
      end
    end
    bus.in_valid = 1'b0;
    step();
    checks++; if (got !== 40 || exp_q.size() !== 0 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_drain got=%0d left=%0d valid=%b exp 40/0/0", got, exp_q.size(), bus.out_valid);
    end
  endtask

  task automatic test_fifo_wrap();
    int sent, got;
    logic [135:0] e;
    do_reset();
    sent = 0; got = 0;
    for (int t = 0; t < 1000 && got < 80; t++) begin
      drive_block(sent, 8'(sent + 8'h80), sent < 80);
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL wrap_extra got=%h/%h", bus.out_data, bus.out_tag); end
        else begin
          e = exp_q.pop_front();
          if ({bus.out_data, bus.out_tag} !== e) begin
            failures++; $display("FAIL wrap_data got=%h/%h exp=%h/%h", bus.out_data, bus.out_tag, e[135:8], e[7:0]);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin exp_q.push_back({vc[sent % 7], 8'(sent + 8'h80)}); sent++; end
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (got !== 80 || bus.out_valid !== 1'b0 || bus.inflight !== 6'd0) begin
      failures++; $display("FAIL wrap_end got=%0d valid=%b inflight=%0d exp 80/0/0", got, bus.out_valid, bus.inflight);
    end
  endtask

  task automatic test_reset_midstream();
    int first, spurious, k;
    do_reset();
    bus.out_ready = 1'b0;
    first = cyc + 1;
    for (int i = 0; i < 15; i++) begin drive_block(i, 8'(8'hE0 + i), 1'b1); step(); end
    bus.in_valid = 1'b0;
    for (int t = 0; t < 40 && cyc < first + 25; t++) step();
    checks++; if (bus.out_valid !== 1'b1 || bus.inflight !== 6'd15) begin
      failures++; $display("FAIL mrst_setup valid=%b inflight=%0d exp 1/15", bus.out_valid, bus.inflight);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.inflight !== 6'd0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL mrst_async valid=%b inflight=%0d ready=%b exp 0/0/1", bus.out_valid, bus.inflight, bus.in_ready);
    end
    step();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.inflight !== 6'd0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL mrst_next valid=%b inflight=%0d ready=%b exp 0/0/1", bus.out_valid, bus.inflight, bus.in_ready);
    end
    spurious = 0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin if (bus.out_valid !== 1'b0) spurious++; step(); end
    checks++; if (spurious !== 0) begin failures++; $display("FAIL mrst_ghost got=%0d exp=0", spurious); end
    bus.out_ready = 1'b0;
    drive_block(1, 8'h3C, 1'b1);
    step();
    bus.in_valid = 1'b0;
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 40) begin step(); k++; end
    checks++; if (k !== 21 || bus.out_data !== vc[1] || bus.out_tag !== 8'h3C) begin
      failures++; $display("FAIL mrst_after lat=%0d data=%h tag=%h exp 21/%h/3c", k, bus.out_data, bus.out_tag, vc[1]);
    end
  endtask

  task automatic test_accept_and_pop();
    int sent;
    logic [135:0] e;
    do_reset();
    sent = 0;
    bus.out_ready = 1'b0;
    for (int t = 0; t < 60; t++) begin
      drive_block(sent, 8'(sent + 8'h20), sent < 31);
      if (bus.in_valid && bus.in_ready) begin exp_q.push_back({vc[sent % 7], 8'(sent + 8'h20)}); sent++; end
      step();
    end
    checks++; if (bus.inflight !== 6'd31 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL sim_setup inflight=%0d ready=%b valid=%b exp 31/1/1", bus.inflight, bus.in_ready, bus.out_valid);
    end
    drive_block(sent, 8'h99, 1'b1);
    bus.out_ready = 1'b1;
    e = exp_q.pop_front();
    checks++; if ({bus.out_data, bus.out_tag} !== e) begin
      failures++; $display("FAIL sim_head got=%h/%h exp=%h/%h", bus.out_data, bus.out_tag, e[135:8], e[7:0]);
    end
    exp_q.push_back({vc[sent % 7], 8'h99});
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.inflight !== 6'd31 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL sim_credit inflight=%0d ready=%b exp 31/1", bus.inflight, bus.in_ready);
    end
    for (int t = 0; t < 100 && exp_q.size() > 0; t++) begin
      if (bus.out_valid) begin
        e = exp_q.pop_front();
        checks++; if ({bus.out_data, bus.out_tag} !== e) begin
          failures++; $display("FAIL sim_drain got=%h/%h exp=%h/%h", bus.out_data, bus.out_tag, e[135:8], e[7:0]);
        end
      end
      step();
    end
    checks++; if (exp_q.size() !== 0 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL sim_end left=%0d valid=%b exp 0/0", exp_q.size(), bus.out_valid);
    end
  endtask

  initial begin
    load_vectors();
    test_reset();
    test_fips();
    test_back_to_back();
    test_backpressure();
    test_fifo_wrap();
    test_reset_midstream();
    test_accept_and_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
